score_hex_display: RTL and testbench
====================================

SCORE_HEX_DISPLAY -- requirements
Module: score_hex_display

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD score digits and seven-segment displays; legal range 1-8.
REQ-002 Parameter BLINK_HALF, default 25000000: clk cycles per blink half-period; legal range 2 or more.
REQ-003 Parameter LZ_BLANK, default 1: when 1, leading zero digits are blanked; digit 0 is never blanked.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 clear  in  1  synchronous score clear; the high score is kept.
REQ-007 inc  in  1  request to add `points` to the score.
REQ-008 points  in  4  BCD addend; values 10-15 are clamped to 9.
REQ-009 dec  in  1  request to subtract 1 from the score.
REQ-010 show_high  in  1  display select: 1 shows the high score, 0 shows the current score.
REQ-011 ready  out  1  high only in IDLE; inc and dec are accepted only while ready=1.
REQ-012 score_bcd  out  4*DIGITS  current score; digit i occupies bits [4i+3:4i].
REQ-013 high_bcd  out  4*DIGITS  high score, same digit packing as score_bcd.
REQ-014 new_high  out  1  one-cycle pulse when the high score is raised.
REQ-015 overflow  out  1  sticky flag, set when the score saturates.
REQ-016 segments  out  7*DIGITS  active-low segments; display i occupies bits [7i+6:7i].

Function
REQ-017 States: IDLE, ADD, SUB, DONE. A digit index idx (0 to DIGITS-1) and a carry/borrow bit are registered.
REQ-018 IDLE with inc=1: latch the clamped points value, set idx=0 and carry=0, then go to ADD.
- inc has priority over dec when both are high.
REQ-019 IDLE with dec=1 and inc=0: set idx=0 and borrow=1, then go to SUB.
REQ-020 ADD, one digit per cycle: s = digit[idx] + addend + carry.
- Digit 0 uses the latched addend; higher digits use addend 0.
- If s > 9: digit = s - 10 and carry = 1; otherwise digit = s and carry = 0.
REQ-021 ADD at idx = DIGITS-1: if carry out is 1, set all digits to 9 and set overflow; in every case go to DONE.
REQ-022 SUB, one digit per cycle: digit = digit - borrow, where digit 0 minus 1 gives 9 with borrow out.
- If the score was 0 when SUB began, it stays 0; there is no wrap to all 9s.
- At idx = DIGITS-1, go to DONE.
REQ-023 DONE lasts one cycle:
- If score_bcd > high_bcd (compared as an unsigned concatenation), load high_bcd from score_bcd, pulse new_high=1 for that cycle, and set the blink flag.
- Then go to IDLE.
REQ-024 Operation latency: with acceptance on edge k, ready is low for DIGITS+1 cycles; the final score is visible after edge k+DIGITS; new_high is high during the cycle after edge k+DIGITS+1.
REQ-025 clear=1 has the highest priority in any state. On the next edge:
- score becomes 0, overflow becomes 0, and the blink flag becomes 0;
- the state goes to IDLE and any in-flight operation is aborted;
- high_bcd is unchanged.
REQ-026 inc or dec asserted while ready=0 is ignored; requests are not queued.
REQ-027 Blink counter: free-running modulo BLINK_HALF; the blink phase toggles on each wrap.
- While the blink flag=1 and the phase=1, all segments are 7'b1111111 (off).
REQ-028 Displayed value: high_bcd when show_high=1, otherwise score_bcd; the selection is combinational with no added latency.
REQ-029 Decode is active-low:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
- Nibbles 10-15 decode to all off.
REQ-030 With LZ_BLANK=1, a digit i>0 is off when it and every higher digit are 0.

Reset
REQ-031 Reset values: state=IDLE, score=0, high=0, overflow=0, new_high=0, blink flag=0, blink counter=0, blink phase=0.
- Resulting outputs: ready=1; segments for display 0 = 1000000; higher displays off when LZ_BLANK=1.
REQ-032 Reset asserted mid-operation aborts at once, without waiting for a clock edge; the partial result is discarded.

Verification (DIGITS=2, BLINK_HALF=4, LZ_BLANK=1)
REQ-033 Reset, then inc with points=5:
- ready is low for 3 cycles;
- score_bcd=0x05, high_bcd=0x05;
- new_high is a single pulse;
- display 0 shows 0010010 and display 1 is off.
REQ-034 With score=0x98, inc with points=7 -> score_bcd=0x99, overflow=1.
REQ-035 With score=0x10, dec -> 0x09; with score=0x00, dec -> 0x00, no wrap, and new_high is not pulsed.
REQ-036 clear asserted during the second ADD cycle -> next edge gives score=0x00, ready=1, high_bcd unchanged, overflow=0.
REQ-037 After a new high: segments alternate between the value and all-off every 4 cycles; clear stops the blinking.
- show_high=1 shows high_bcd digits immediately.
REQ-038 Reset asserted asynchronously mid-SUB -> outputs take the REQ-031 values before the next clk edge.

Source files
------------

// File: rtl/score_hex_display.sv
// ============================================================================
//  Module      : score_hex_display
//  Description : BCD score keeper with saturating add, floored decrement,
//                high-score tracking with blink, and active-low 7-segment
//                decode with optional leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_hex_display #(
  parameter int DIGITS     = 2,
  parameter int BLINK_HALF = 25000000,
  parameter int LZ_BLANK   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_inc,
  input  logic [3:0]            i_points,
  input  logic                  i_dec,
  input  logic                  i_show_high,
  output logic                  o_ready,
  output logic [4*DIGITS-1:0]   o_score_bcd,
  output logic [4*DIGITS-1:0]   o_high_bcd,
  output logic                  o_new_high,
  output logic                  o_overflow,
  output logic [7*DIGITS-1:0]   o_segments
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(BLINK_HALF);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_carry;      // carry during ADD, borrow during SUB
  logic [3:0]            r_addend;
  logic [4*DIGITS-1:0]   r_score;
  logic [4*DIGITS-1:0]   r_high;
  logic                  r_new_high;
  logic                  r_overflow;
  logic                  r_blink_en;
  logic [CNT_W-1:0]      r_blink_cnt;
  logic                  r_blink_phase;

  logic [3:0]            w_cur;
  logic [3:0]            w_addend;
  logic [4:0]            w_sum;
  logic [4:0]            w_sum_adj;
  logic                  w_sum_gt9;
  logic [3:0]            w_add_dig;
  logic                  w_sub_borrow;
  logic [3:0]            w_sub_dig;
  logic [3:0]            w_points_clamped;
  logic [4*DIGITS-1:0]   w_disp;
  logic                  w_lead_nz;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'b1000000;
      4'd1:    f_decode = 7'b1111001;
      4'd2:    f_decode = 7'b0100100;
      4'd3:    f_decode = 7'b0110000;
      4'd4:    f_decode = 7'b0011001;
      4'd5:    f_decode = 7'b0010010;
      4'd6:    f_decode = 7'b0000010;
      4'd7:    f_decode = 7'b1111000;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0011000;
      default: f_decode = 7'b1111111;
    endcase
  endfunction

  // Select the digit currently addressed by the serial add/sub engine
  always_comb begin
    w_cur = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) w_cur = r_score[4*i +: 4];
    end
  end

  // One-digit BCD add and subtract datapath
  always_comb begin
    w_points_clamped = (i_points > 4'd9) ? 4'd9 : i_points;
    w_addend         = (r_idx == '0) ? r_addend : 4'd0;
    w_sum            = {1'b0, w_cur} + {1'b0, w_addend} + {4'd0, r_carry};
    w_sum_adj        = w_sum - 5'd10;
    w_sum_gt9        = (w_sum > 5'd9);
    w_add_dig        = w_sum_gt9 ? w_sum_adj[3:0] : w_sum[3:0];
    w_sub_borrow     = r_carry && (w_cur == 4'd0);
    w_sub_dig        = w_sub_borrow ? 4'd9 : (w_cur - {3'd0, r_carry});
  end

  // Control FSM and score/high-score registers; clear overrides everything but reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_addend   <= 4'd0;
      r_score    <= '0;
      r_high     <= '0;
      r_new_high <= 1'b0;
      r_overflow <= 1'b0;
      r_blink_en <= 1'b0;
    end else if (i_clear) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_score    <= '0;
      r_new_high <= 1'b0;
      r_overflow <= 1'b0;
      r_blink_en <= 1'b0;
    end else begin
      r_new_high <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_inc) begin
            r_addend <= w_points_clamped;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_state  <= S_ADD;
          end else if (i_dec) begin
            // A zero score starts with no borrow, so it stays at zero
            r_idx    <= '0;
            r_carry  <= |r_score;
            r_state  <= S_SUB;
          end
        end
        S_ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) r_score[4*i +: 4] <= w_add_dig;
          end
          r_carry <= w_sum_gt9;
          if (r_idx == c_last_idx) begin
            r_state <= S_DONE;
            if (w_sum_gt9) begin
              r_score    <= {DIGITS{4'h9}};
              r_overflow <= 1'b1;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_SUB: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) r_score[4*i +: 4] <= w_sub_dig;
          end
          r_carry <= w_sub_borrow;
          if (r_idx == c_last_idx) r_state <= S_DONE;
          else                     r_idx   <= r_idx + 1'b1;
        end
        S_DONE: begin
          if (r_score > r_high) begin
            r_high     <= r_score;
            r_new_high <= 1'b1;
            r_blink_en <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Free-running blink timebase; phase flips each time the counter wraps
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == c_cnt_max) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  // Display source select, leading-zero blanking, blink and decode
  always_comb begin
    o_segments = '1;
    w_disp     = i_show_high ? r_high : r_score;
    w_lead_nz  = 1'b0;
    w_nib      = 4'd0;
    w_seg      = 7'b1111111;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_nib     = w_disp[4*i +: 4];
      w_lead_nz = w_lead_nz | (w_nib != 4'd0);
      w_seg     = f_decode(w_nib);
      if ((LZ_BLANK != 0) && (i > 0) && !w_lead_nz) w_seg = 7'b1111111;
      if (r_blink_en && r_blink_phase)              w_seg = 7'b1111111;
      o_segments[7*i +: 7] = w_seg;
    end
  end

  assign o_ready     = (r_state == S_IDLE);
  assign o_score_bcd = r_score;
  assign o_high_bcd  = r_high;
  assign o_new_high  = r_new_high;
  assign o_overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_score_hex_display.sv
// ============================================================================
//  Module      : tb_score_hex_display
//  Description : Self-checking bench for score_hex_display (DIGITS=2,
//                BLINK_HALF=4, LZ_BLANK=1) against an integer score model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_hex_display;

  localparam int DIGITS     = 2;
  localparam int BLINK_HALF = 4;
  localparam int LZ_BLANK   = 1;
  localparam int MAXV       = 99;

  logic clk = 1'b0;
  logic rst;
  logic i_clear, i_inc, i_dec, i_show_high;
  logic [3:0] i_points;
  logic o_ready, o_new_high, o_overflow;
  logic [4*DIGITS-1:0] o_score_bcd, o_high_bcd;
  logic [7*DIGITS-1:0] o_segments;

  score_hex_display #(
    .DIGITS     (DIGITS),
    .BLINK_HALF (BLINK_HALF),
    .LZ_BLANK   (LZ_BLANK)
  ) u_dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_clear     (i_clear),
    .i_inc       (i_inc),
    .i_points    (i_points),
    .i_dec       (i_dec),
    .i_show_high (i_show_high),
    .o_ready     (o_ready),
    .o_score_bcd (o_score_bcd),
    .o_high_bcd  (o_high_bcd),
    .o_new_high  (o_new_high),
    .o_overflow  (o_overflow),
    .o_segments  (o_segments)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integers
  int m_score, m_high;
  bit m_ovf, m_blink;
  int edge_n;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_seg(input int v, input bit blank);
    logic [6:0] tab [10];
    int p;
    int d;
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
    exp_seg = '1;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = (v / p) % 10;
      if (!blank && !(LZ_BLANK != 0 && i > 0 && v < p))
        exp_seg[7*i +: 7] = tab[d];
      p = p * 10;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_disp(input string tag);
    int v;
    bit blank;
    v     = i_show_high ? m_high : m_score;
    blank = m_blink && (((edge_n / BLINK_HALF) % 2) == 1);
    chk(tag, 32'(o_segments), 32'(exp_seg(v, blank)));
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_score"}, 32'(o_score_bcd), 32'(to_bcd(m_score)));
    chk({tag, "_high"},  32'(o_high_bcd),  32'(to_bcd(m_high)));
    chk({tag, "_ovf"},   32'(o_overflow),  32'(m_ovf));
  endtask

  // kind 0 = inc, 1 = dec; stray requests during the busy window must be ignored
  task automatic do_op(input int kind, input int pts, input bit strays);
    int  prev_high;
    bit  exp_pulse;
    chk("ready_before", 32'(o_ready), 32'd1);
    i_inc    = (kind == 0);
    i_dec    = (kind == 1);
    i_points = 4'(pts);
    tick();
    i_inc = 1'b0;
    i_dec = 1'b0;
    prev_high = m_high;
    if (kind == 0) begin
      m_score = m_score + ((pts > 9) ? 9 : pts);
      if (m_score > MAXV) begin
        m_score = MAXV;
        m_ovf   = 1'b1;
      end
    end else if (m_score > 0) begin
      m_score = m_score - 1;
    end
    exp_pulse = (m_score > prev_high);
    for (int c = 0; c <= DIGITS; c++) begin
      chk("busy", 32'(o_ready), 32'd0);
      if (c == DIGITS) chk("score_final", 32'(o_score_bcd), 32'(to_bcd(m_score)));
      if (strays) begin
        i_inc    = 1'($urandom_range(0, 1));
        i_dec    = 1'($urandom_range(0, 1));
        i_points = 4'($urandom_range(0, 15));
      end
      tick();
    end
    i_inc = 1'b0;
    i_dec = 1'b0;
    if (exp_pulse) begin
      m_high  = m_score;
      m_blink = 1'b1;
    end
    i_show_high = 1'($urandom_range(0, 1));
    #1;
    chk("ready_after", 32'(o_ready), 32'd1);
    chk("new_high", 32'(o_new_high), 32'(exp_pulse));
    check_state("op");
    check_disp("seg_op");
    tick();
    chk("new_high_single", 32'(o_new_high), 32'd0);
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    m_score = 0;
    m_ovf   = 1'b0;
    m_blink = 1'b0;
    chk("clr_ready", 32'(o_ready), 32'd1);
    check_state("clr");
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      i_show_high = 1'($urandom_range(0, 1));
      #1;
      check_disp("seg_idle");
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; i_clear = 1'b0; i_inc = 1'b0; i_dec = 1'b0;
    i_show_high = 1'b0; i_points = 4'd0;
    m_score = 0; m_high = 0; m_ovf = 1'b0; m_blink = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_new_high", 32'(o_new_high), 32'd0);
    check_state("rst");
    chk("rst_seg", 32'(o_segments), 32'({7'b1111111, 7'b1000000}));

    // First inc of 5: new high, then blinking over idle cycles
    do_op(0, 5, 1'b0);
    i_show_high = 1'b0;
    #1;
    if (((edge_n / BLINK_HALF) % 2) == 0)
      chk("seg_five", 32'(o_segments), 32'({7'b1111111, 7'b0010010}));
    idle_cycles(12);
    do_clear();
    idle_cycles(6);

    // Clamp, climb to 98, then saturate
    do_op(0, 15, 1'b1);
    for (int k = 0; k < 9; k++) do_op(0, 9, 1'b0);
    do_op(0, 8, 1'b0);
    chk("at98", 32'(o_score_bcd), 32'h98);
    do_op(0, 7, 1'b0);
    chk("sat99", 32'(o_score_bcd), 32'h99);
    chk("ovf_set", 32'(o_overflow), 32'd1);
    do_clear();

    // Decrement across a digit boundary, then at zero
    do_op(0, 9, 1'b0);
    do_op(0, 1, 1'b0);
    do_op(1, 0, 1'b1);
    chk("dec_to_09", 32'(o_score_bcd), 32'h09);
    do_clear();
    do_op(1, 0, 1'b0);
    chk("dec_floor", 32'(o_score_bcd), 32'h00);

    // Clear during the second ADD cycle
    do_op(0, 4, 1'b0);
    i_inc = 1'b1; i_points = 4'd7;
    tick();
    i_inc = 1'b0;
    tick();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    m_score = 0; m_ovf = 1'b0; m_blink = 1'b0;
    chk("midclr_ready", 32'(o_ready), 32'd1);
    check_state("midclr");
    idle_cycles(3);

    // Randomized operation mix
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      do_clear();
      else if (r <= 3) do_op(1, 0, 1'($urandom_range(0, 1)));
      else             do_op(0, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a SUB
    do_op(0, 4, 1'b0);
    i_dec = 1'b1;
    tick();
    i_dec = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    m_score = 0; m_high = 0; m_ovf = 1'b0; m_blink = 1'b0;
    chk("arst_ready", 32'(o_ready), 32'd1);
    chk("arst_new_high", 32'(o_new_high), 32'd0);
    check_state("arst");
    chk("arst_seg", 32'(o_segments), 32'({7'b1111111, 7'b1000000}));
    @(posedge clk);
    #1 rst = 1'b0;
    do_op(0, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
